// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_pkg
//  Description : Shared constants, parser state encoding and frame helper
//                for the UART command frame decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmd_pkg;

  localparam logic [7:0] HEADER = 8'h55;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_CMD = 2'd1,
    ST_GET_CHK = 2'd2
  } parser_state_t;

  localparam logic [7:0] CMD_GRAY_OFF   = 8'h60;
  localparam logic [7:0] CMD_GRAY_ON    = 8'h61;
  localparam logic [7:0] CMD_BRIGHT_RST = 8'h70;
  localparam logic [4:0] CMD_BRIGHT_UP  = 5'b01110;
  localparam logic [4:0] CMD_BRIGHT_DN  = 5'b01111;
  localparam logic [7:0] CMD_HUE_RST    = 8'h80;
  localparam logic [4:0] CMD_HUE_UP     = 5'b10000;
  localparam logic [4:0] CMD_HUE_DN     = 5'b10001;

  // A frame is valid when the check byte is the bitwise complement of cmd.
  function automatic logic check_byte_ok(input logic [7:0] cmd, input logic [7:0] chk);
    return (chk == ~cmd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fifo
//  Description : Small synchronous FIFO; a push while full succeeds when a
//                pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int              c_aw      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == c_depth);
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_frame_decoder
//  Description : Parses header/cmd/complement UART frames, queues accepted
//                commands and issues them as rate-limited strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_frame_decoder #(
  parameter logic [7:0] HEADER         = cmd_pkg::HEADER,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter int         GAP_CYCLES     = 4,
  parameter int         FIFO_DEPTH     = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       command_flag,
  output logic [3:0] ctrl_command_out,
  output logic [3:0] value_command_out,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       fifo_full
);

  import cmd_pkg::*;

  localparam int                c_to_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 2);
  localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);
  localparam logic [7:0]        c_gap     = 8'(GAP_CYCLES);
  localparam logic [7:0]        c_one8    = 8'd1;

  parser_state_t     r_state;
  parser_state_t     w_state_nxt;
  logic [7:0]        r_cmd;
  logic [7:0]        w_cmd_nxt;
  logic [c_to_w-1:0] r_to_cnt;
  logic              w_to_hit;
  logic              w_push;
  logic              w_parse_err;
  logic              w_drop;
  logic              w_err;
  logic              w_pop;
  logic [7:0]        w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [7:0]        r_gap;
  logic              r_cmd_flag;
  logic [3:0]        r_ctrl;
  logic [3:0]        r_value;
  logic              r_frame_err;
  logic [7:0]        r_err_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
    end
  end

  // The counter reaches TIMEOUT_CYCLES-1 on the edge that declares the timeout.
  assign w_to_hit = (r_to_cnt == c_to_last);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE || rx_valid) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + c_to_one;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_push      = 1'b0;
    w_parse_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid && rx_data == HEADER) w_state_nxt = ST_GET_CMD;
      end
      ST_GET_CMD: begin
        if (rx_valid) begin
          w_cmd_nxt   = rx_data;
          w_state_nxt = ST_GET_CHK;
        end else if (w_to_hit) begin
          w_parse_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GET_CHK: begin
        if (rx_valid) begin
          if (check_byte_ok(r_cmd, rx_data)) w_push = 1'b1;
          else                                w_parse_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_to_hit) begin
          w_parse_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_cmd),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_dout),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign w_pop  = !w_fifo_empty && (r_gap == '0);
  assign w_drop = w_push && w_fifo_full && !w_pop;
  assign w_err  = w_parse_err || w_drop;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_flag <= 1'b0;
      r_ctrl     <= '0;
      r_value    <= '0;
      r_gap      <= '0;
    end else begin
      r_cmd_flag <= w_pop;
      if (w_pop) begin
        r_ctrl  <= w_fifo_dout[7:4];
        r_value <= w_fifo_dout[3:0];
        r_gap   <= c_gap;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - c_one8;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + c_one8;
    end
  end

  assign command_flag      = r_cmd_flag;
  assign ctrl_command_out  = r_ctrl;
  assign value_command_out = r_value;
  assign frame_err         = r_frame_err;
  assign err_cnt           = r_err_cnt;
  assign fifo_full         = w_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_frame_decoder
//  Description : Directed plus random frames against a queue-based reference
//                model, with a scoreboard monitor on strobes and errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_frame_decoder;

  localparam int TB_TIMEOUT = 100;
  localparam int TB_GAP     = 200;
  localparam int TB_DEPTH   = 4;

  logic       sys_clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       command_flag;
  logic [3:0] ctrl_command_out;
  logic [3:0] value_command_out;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       fifo_full;

  uart_cmd_frame_decoder #(
    .HEADER         (8'h55),
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .GAP_CYCLES     (TB_GAP),
    .FIFO_DEPTH     (TB_DEPTH)
  ) dut (
    .sys_clk           (sys_clk),
    .rst_n             (rst_n),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .command_flag      (command_flag),
    .ctrl_command_out  (ctrl_command_out),
    .value_command_out (value_command_out),
    .frame_err         (frame_err),
    .err_cnt           (err_cnt),
    .fifo_full         (fifo_full)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t       sq[$];
  int         eq[$];
  logic [7:0] mq[$];
  int         strobe_cyc[$];
  int         n_strobes       = 0;
  int         last_strobe_cyc = -1;
  int         last_err_cyc    = -1;

  // Reference model: frame stage, silence length, pending command list.
  int         m_stage   = 0;
  int         m_idle    = 0;
  logic [7:0] m_cmd     = 8'h00;
  int         m_next_ok = 0;
  int         m_errcnt  = 0;
  logic       m_full    = 1'b0;
  logic [7:0] m_last    = 8'h00;
  logic       m_err;
  logic       m_push;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage = 0; m_idle = 0; m_cmd = 8'h00; m_next_ok = 0;
      m_errcnt = 0; m_full = 1'b0; m_last = 8'h00;
      sq.delete(); eq.delete(); mq.delete();
    end else begin
      cyc++;
      m_err  = 1'b0;
      m_push = 1'b0;
      if (rx_valid) begin
        m_idle = 0;
        if (m_stage == 0) begin
          if (rx_data == 8'h55) m_stage = 1;
        end else if (m_stage == 1) begin
          m_cmd   = rx_data;
          m_stage = 2;
        end else begin
          if ((rx_data ^ m_cmd) == 8'hFF) m_push = 1'b1;
          else                            m_err  = 1'b1;
          m_stage = 0;
        end
      end else if (m_stage != 0) begin
        m_idle++;
        if (m_idle == TB_TIMEOUT - 1) begin
          m_err   = 1'b1;
          m_stage = 0;
        end
      end
      if (mq.size() > 0 && cyc >= m_next_ok) begin
        exp_t e;
        e.cyc = cyc;
        e.b   = mq.pop_front();
        sq.push_back(e);
        m_last    = e.b;
        m_next_ok = cyc + TB_GAP + 1;
      end
      if (m_push) begin
        if (mq.size() == TB_DEPTH) m_err = 1'b1;
        else                       mq.push_back(m_cmd);
      end
      if (m_err) begin
        eq.push_back(cyc);
        if (m_errcnt != 255) m_errcnt++;
      end
      m_full = (mq.size() == TB_DEPTH);
    end
  end

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      checks++;
      if (command_flag !== 1'b0 || ctrl_command_out !== 4'h0 || value_command_out !== 4'h0 ||
          frame_err !== 1'b0 || err_cnt !== 8'h00 || fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got flag=%0b ctrl=%0h value=%0h err=%0b cnt=%0d full=%0b, expected all 0",
                 command_flag, ctrl_command_out, value_command_out, frame_err, err_cnt, fifo_full);
      end
    end else begin
      if (command_flag) begin
        n_strobes++;
        last_strobe_cyc = cyc;
        strobe_cyc.push_back(cyc);
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got ctrl=%0h value=%0h at cycle %0d, expected no strobe",
                   ctrl_command_out, value_command_out, cyc);
        end else begin
          if (sq[0].cyc != cyc || ctrl_command_out !== sq[0].b[7:4] || value_command_out !== sq[0].b[3:0]) begin
            errors++;
            $display("FAIL strobe: got ctrl=%0h value=%0h at cycle %0d, expected ctrl=%0h value=%0h at cycle %0d",
                     ctrl_command_out, value_command_out, cyc, sq[0].b[7:4], sq[0].b[3:0], sq[0].cyc);
          end
          sq.delete(0);
        end
      end else if (sq.size() > 0 && sq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL strobe_missing: got none by cycle %0d, expected cmd %0h at cycle %0d", cyc, sq[0].b, sq[0].cyc);
        sq.delete(0);
      end
      if (frame_err) begin
        last_err_cyc = cyc;
        checks++;
        if (eq.size() == 0 || eq[0] != cyc) begin
          errors++;
          $display("FAIL frame_err: got pulse at cycle %0d, expected at cycle %0d", cyc,
                   (eq.size() == 0) ? -1 : eq[0]);
        end
        if (eq.size() > 0 && eq[0] <= cyc) eq.delete(0);
      end else if (eq.size() > 0 && eq[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL frame_err_missing: got none by cycle %0d, expected at cycle %0d", cyc, eq[0]);
        eq.delete(0);
      end
      checks++;
      if (int'(err_cnt) != m_errcnt) begin
        errors++;
        $display("FAIL err_cnt: got %0d, expected %0d at cycle %0d", err_cnt, m_errcnt, cyc);
      end
      checks++;
      if (fifo_full !== m_full) begin
        errors++;
        $display("FAIL fifo_full: got %0b, expected %0b at cycle %0d", fifo_full, m_full, cyc);
      end
      checks++;
      if ({ctrl_command_out, value_command_out} !== m_last) begin
        errors++;
        $display("FAIL cmd_hold: got %0h, expected %0h at cycle %0d",
                 {ctrl_command_out, value_command_out}, m_last, cyc);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(posedge sys_clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
  endtask

  task automatic frame(input logic [7:0] c);
    put(8'h55);
    put(c);
    put(~c);
  endtask

  initial begin
    int         k;
    int         base;
    int         guard;
    logic [7:0] c;
    logic [7:0] burst [6];

    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Single frame with spaced bytes.
    put(8'h55); idle(9); put(8'h71); idle(9); put(8'h8E);
    k = cyc + 1;
    idle(20);
    check("single_count", n_strobes, 1);
    check("single_latency", last_strobe_cyc, k + 1);
    check("single_ctrl", int'(ctrl_command_out), 7);
    check("single_value", int'(value_command_out), 1);
    check("single_err_cnt", int'(err_cnt), 0);
    idle(TB_GAP);

    // Bad complement, then a good frame.
    frame(8'h61);
    rx_data = 8'h9F;
    idle(5);
    check("bad_err_cnt", int'(err_cnt), 1);
    check("bad_no_strobe", n_strobes, 1);
    frame(8'h60);
    idle(5);
    check("good_after_bad_count", n_strobes, 2);
    check("good_after_bad_ctrl", int'(ctrl_command_out), 6);
    check("good_after_bad_value", int'(value_command_out), 0);
    idle(TB_GAP);

    // Timeout inside a frame; late check byte must be ignored.
    put(8'h55); put(8'h80);
    k = cyc + 1;
    idle(TB_TIMEOUT + 5);
    check("timeout_cycle", last_err_cyc, k + TB_TIMEOUT - 1);
    check("timeout_err_cnt", int'(err_cnt), 2);
    put(8'h7F); idle(10);
    check("late_chk_no_strobe", n_strobes, 2);
    check("late_chk_err_cnt", int'(err_cnt), 2);
    idle(TB_GAP);

    // Burst of six back-to-back frames into a four-deep FIFO.
    burst[0] = 8'h70; burst[1] = 8'h61; burst[2] = 8'h80;
    burst[3] = 8'h60; burst[4] = 8'h71; burst[5] = 8'h81;
    base = n_strobes;
    for (int i = 0; i < 6; i++) begin
      put(8'h55);
      if (i == 5) check("burst_fifo_full", int'(fifo_full), 1);
      put(burst[i]);
      put(~burst[i]);
    end
    idle(5 * (TB_GAP + 1) + 20);
    check("burst_count", n_strobes, base + 5);
    for (int i = 1; i < 5; i++)
      check("burst_spacing", strobe_cyc[base + i] - strobe_cyc[base + i - 1], TB_GAP + 1);
    check("burst_err_cnt", int'(err_cnt), 3);
    check("burst_last_ctrl", int'(ctrl_command_out), 7);
    check("burst_last_value", int'(value_command_out), 1);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      put(8'h55); put(8'h00); put(8'h00);
    end
    idle(3);
    check("sat_err_cnt", int'(err_cnt), 255);
    idle(5);
    check("sat_err_cnt_hold", int'(err_cnt), 255);

    // Reset in the middle of a frame.
    base = n_strobes;
    put(8'h55); put(8'h78); idle(1);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    idle(2);
    put(8'h87);
    idle(TB_GAP + 10);
    check("rst_mid_no_strobe", n_strobes, base);
    check("rst_mid_err_cnt", int'(err_cnt), 0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      c = 8'($urandom);
      if (k < 5) begin
        frame(c);
      end else if (k < 7) begin
        put(8'h55); put(c); put(~c ^ 8'(1 << $urandom_range(0, 7)));
      end else if (k < 8) begin
        put(8'($urandom));
      end else if (k < 9) begin
        put(8'h55); put(c); idle(TB_TIMEOUT + $urandom_range(0, 3));
      end else begin
        idle($urandom_range(1, 10));
      end
      idle($urandom_range(0, 2));
    end
    idle(1);

    guard = 0;
    while ((sq.size() > 0 || eq.size() > 0 || mq.size() > 0) && guard < 3000) begin
      @(posedge sys_clk);
      guard++;
    end
    idle(3);
    checks++;
    if (sq.size() > 0 || eq.size() > 0 || mq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d strobes and %0d errors still pending, expected none", sq.size(), eq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
